// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the sync_fifo_fwft family: read-mode encodings and
// an elaboration-time log2 helper used to validate the address width.
package sync_fifo_fwft_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset; flush/reset only move the pointers.
module fifo_mem #(
    parameter int unsigned data_width   = 8,
    parameter int unsigned fifo_depth   = 16,
    parameter int unsigned address_size = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [address_size-1:0] waddr,
    input  logic [data_width-1:0]   wdata,
    input  logic [address_size-1:0] raddr,
    output logic [data_width-1:0]   rdata
);

    logic [data_width-1:0] mem [fifo_depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy count, programmable almost flags, synchronous
// flush and a selectable standard (registered) or first-word-fall-through read path.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int unsigned data_width   = 8,
    parameter int unsigned fifo_depth   = 16,
    parameter int unsigned address_size = 4,
    parameter int unsigned fwft_mode    = FIFO_MODE_STD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [data_width-1:0]   w_data,
    input  logic                    rd_en,
    input  logic [address_size:0]   af_thresh,
    input  logic [address_size:0]   ae_thresh,
    output logic [data_width-1:0]   r_data,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [address_size:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned pw = address_size + 1;

    if (address_size != fifo_clog2(fifo_depth) || fifo_depth != (32'd1 << address_size)
        || fifo_depth < 4) begin : g_param_check
        $error("sync_fifo_fwft: fifo_depth must be a power of two >= 4 and address_size its log2");
    end

    logic [pw-1:0]         wr_ptr;
    logic [pw-1:0]         rd_ptr;
    logic [data_width-1:0] head_data;
    logic                  wr_acc;
    logic                  rd_acc;

    // Extra wrap bit makes the pointer difference span 0..fifo_depth exactly.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == pw'(fifo_depth));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // Acceptance looks at current state only; flush overrides both requests.
    assign wr_acc = wr_en && !full  && !clear;
    assign rd_acc = rd_en && !empty && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + pw'(1);
            if (rd_acc) rd_ptr <= rd_ptr + pw'(1);
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    fifo_mem #(
        .data_width   (data_width),
        .fifo_depth   (fifo_depth),
        .address_size (address_size)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[address_size-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr[address_size-1:0]),
        .rdata (head_data)
    );

    if (fwft_mode == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly; masked to zero while nothing is stored.
        assign r_data = empty ? '0 : head_data;
        assign valid  = !empty;
    end else begin : g_std
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_data <= '0;
                valid  <= 1'b0;
            end else if (rd_acc) begin
                r_data <= head_data;
                valid  <= 1'b1;
            end else begin
                valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: a standard and an FWFT instance share one
// stimulus stream and are checked each cycle against a queue-based reference.
module tb_sync_fifo_fwft;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          clear     = 1'b0;
    logic          wr_en     = 1'b0;
    logic          rd_en     = 1'b0;
    logic [DW-1:0] w_data    = '0;
    logic [AW:0]   af_thresh = 5'd12;
    logic [AW:0]   ae_thresh = 5'd3;

    logic [DW-1:0] s_r_data, f_r_data;
    logic          s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [AW:0]   s_count, f_count;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_sd;
    logic          exp_sv, exp_ovf, exp_unf;
    int            n_pass, n_total;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.data_width(DW), .fifo_depth(DEPTH), .address_size(AW), .fwft_mode(0)) u_std (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .r_data(s_r_data), .valid(s_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_fwft #(.data_width(DW), .fifo_depth(DEPTH), .address_size(AW), .fwft_mode(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .r_data(f_r_data), .valid(f_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string ph);
        int            n;
        logic [DW-1:0] head;
        n    = mq.size();
        head = (n != 0) ? mq[0] : '0;
        chk({ph, " s_count"}, 32'(s_count), 32'(n));
        chk({ph, " f_count"}, 32'(f_count), 32'(n));
        chk({ph, " s_empty"}, 32'(s_empty), 32'(n == 0));
        chk({ph, " f_empty"}, 32'(f_empty), 32'(n == 0));
        chk({ph, " s_full"},  32'(s_full),  32'(n == DEPTH));
        chk({ph, " f_full"},  32'(f_full),  32'(n == DEPTH));
        chk({ph, " s_af"},    32'(s_af),    32'(n >= int'(af_thresh)));
        chk({ph, " f_af"},    32'(f_af),    32'(n >= int'(af_thresh)));
        chk({ph, " s_ae"},    32'(s_ae),    32'(n <= int'(ae_thresh)));
        chk({ph, " f_ae"},    32'(f_ae),    32'(n <= int'(ae_thresh)));
        chk({ph, " s_ovf"},   32'(s_ovf),   32'(exp_ovf));
        chk({ph, " f_ovf"},   32'(f_ovf),   32'(exp_ovf));
        chk({ph, " s_unf"},   32'(s_unf),   32'(exp_unf));
        chk({ph, " f_unf"},   32'(f_unf),   32'(exp_unf));
        chk({ph, " s_valid"}, 32'(s_valid), 32'(exp_sv));
        chk({ph, " s_rdata"}, 32'(s_r_data), 32'(exp_sd));
        chk({ph, " f_valid"}, 32'(f_valid), 32'(n != 0));
        chk({ph, " f_rdata"}, 32'(f_r_data), 32'(head));
    endtask

    // One clock of stimulus; the reference predicts acceptance from pre-edge occupancy.
    task automatic tick(input logic wr, input logic [DW-1:0] wd, input logic rd,
                        input logic clr, input string ph);
        int n;
        bit fl, em;
        n  = mq.size();
        fl = (n == DEPTH);
        em = (n == 0);
        wr_en  = wr;
        w_data = wd;
        rd_en  = rd;
        clear  = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            mq.delete();
            exp_sv  = 1'b0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = wr && fl;
            exp_unf = rd && em;
            if (rd && !em) begin
                exp_sd = mq.pop_front();
                exp_sv = 1'b1;
            end else begin
                exp_sv = 1'b0;
            end
            if (wr && !fl) mq.push_back(wd);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        check_all(ph);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_sd  = '0;
        exp_sv  = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset");
        reset = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        for (int i = 1; i <= 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        tick(1'b1, 8'h11, 1'b0, 1'b0, "overflow");
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        tick(1'b0, 8'h00, 1'b1, 1'b0, "underflow");

        tick(1'b1, 8'hA5, 1'b0, 1'b0, "single_wr");
        tick(1'b0, 8'h00, 1'b1, 1'b0, "single_rd");

        for (int i = 0; i < 16; i++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "fill2");
        tick(1'b1, 8'hEE, 1'b1, 1'b0, "both_full");
        for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        tick(1'b1, 8'h3C, 1'b1, 1'b0, "both_empty");
        tick(1'b0, 8'h00, 1'b1, 1'b0, "drain3");

        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "prime");
        for (int i = 0; i < 40; i++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, "wrap");
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, 1'b0, "unprime");

        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_clear");
        tick(1'b1, 8'h77, 1'b1, 1'b1, "clear");
        tick(1'b0, 8'h00, 1'b0, 1'b0, "post_clear");

        af_thresh = 5'd0;
        ae_thresh = 5'd16;
        tick(1'b0, 8'h00, 1'b0, 1'b0, "thr_zero");
        tick(1'b1, 8'h5B, 1'b0, 1'b0, "thr_one");
        af_thresh = 5'd17;
        ae_thresh = 5'd31;
        tick(1'b0, 8'h00, 1'b0, 1'b0, "thr_high");
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        tick(1'b0, 8'h00, 1'b1, 1'b0, "thr_restore");

        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "burst");
        wr_en  = 1'b1;
        w_data = 8'h5A;
        rd_en  = 1'b1;
        #2 reset = 1'b1;
        #1;
        mq.delete();
        exp_sd  = '0;
        exp_sv  = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all("arst_now");
        @(posedge clk);
        #1;
        check_all("arst_hold");
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0, "post_arst");
        tick(1'b1, 8'hC3, 1'b0, 1'b0, "post_arst_wr");
        tick(1'b0, 8'h00, 1'b1, 1'b0, "post_arst_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
